// File: rtl/fetch_ctl.sv
// fetch_ctl: KT8 instruction fetch / relative-branch sequencer.
// Fetches the opcode at pc_i, resolves branches against Z, hands other opcodes
// to execute, and issues one PC-advance strobe per instruction.
module fetch_ctl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pc_i,
  output logic [7:0] mem_addr_o,
  output logic       mem_req_o,
  input  logic       mem_ack_i,
  input  logic [7:0] mem_data_i,
  input  logic       flag_z_i,
  output logic [7:0] instr_o,
  output logic       instr_valid_o,
  input  logic       exec_done_i,
  output logic       pc_adv_o,
  output logic       jump_up_o,
  output logic       jump_down_o,
  output logic [3:0] jump_dist_o,
  output logic       halted_o,
  output logic       fault_o
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_opcode, w_opcode_nxt;

  logic       r_mem_req, w_mem_req;
  logic [7:0] r_instr, w_instr;
  logic       r_instr_valid, w_instr_valid;
  logic       r_pc_adv, w_pc_adv;
  logic       r_jump_up, w_jump_up;
  logic       r_jump_down, w_jump_down;
  logic [3:0] r_jump_dist, w_jump_dist;
  logic       r_halted, w_halted;
  logic       r_fault, w_fault;

  logic [3:0] w_op;
  logic       w_is_branch;
  logic       w_taken;

  // Opcode field decode: C/D unconditional, E/F taken only when Z is set.
  assign w_op        = r_opcode[7:4];
  assign w_is_branch = (w_op[3:2] == 2'b11);
  assign w_taken     = ~w_op[1] | flag_z_i;

  assign mem_addr_o    = pc_i;
  assign mem_req_o     = r_mem_req;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_instr_valid;
  assign pc_adv_o      = r_pc_adv;
  assign jump_up_o     = r_jump_up;
  assign jump_down_o   = r_jump_down;
  assign jump_dist_o   = r_jump_dist;
  assign halted_o      = r_halted;
  assign fault_o       = r_fault;

  // State, timeout counter and latched opcode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_FETCH;
      r_cnt    <= '0;
      r_opcode <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_opcode <= w_opcode_nxt;
    end
  end

  // Next state plus the output values that belong to that next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_opcode_nxt  = r_opcode;
    w_jump_up     = 1'b0;
    w_jump_down   = 1'b0;
    w_jump_dist   = 4'd0;

    case (r_state)
      S_FETCH: begin
        // The request is only live once the registered req is up (not in the post-reset cycle).
        if (r_mem_req) begin
          if (mem_ack_i) begin
            w_opcode_nxt = mem_data_i;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DECODE;
          end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_FAULT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DECODE: begin
        if (w_is_branch) begin
          w_state_nxt = S_ADVANCE;
          if (w_taken) begin
            w_jump_up   = ~w_op[0];
            w_jump_down = w_op[0];
            w_jump_dist = r_opcode[3:0];
          end
        end else if (r_opcode == 8'h00) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          w_state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: w_state_nxt = S_FETCH;
      S_HALT:    w_state_nxt = S_HALT;
      S_FAULT:   w_state_nxt = S_FAULT;
      default:   w_state_nxt = S_FETCH;
    endcase

    w_mem_req     = (w_state_nxt == S_FETCH);
    w_instr_valid = (w_state_nxt == S_EXEC);
    w_instr       = w_instr_valid ? w_opcode_nxt : 8'h00;
    w_pc_adv      = (w_state_nxt == S_ADVANCE);
    w_halted      = (w_state_nxt == S_HALT);
    w_fault       = (w_state_nxt == S_FAULT);
  end

  // Output registers; reset forces every strobe/flag low immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_req     <= 1'b0;
      r_instr       <= 8'h00;
      r_instr_valid <= 1'b0;
      r_pc_adv      <= 1'b0;
      r_jump_up     <= 1'b0;
      r_jump_down   <= 1'b0;
      r_jump_dist   <= 4'd0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_mem_req     <= w_mem_req;
      r_instr       <= w_instr;
      r_instr_valid <= w_instr_valid;
      r_pc_adv      <= w_pc_adv;
      r_jump_up     <= w_jump_up;
      r_jump_down   <= w_jump_down;
      r_jump_dist   <= w_jump_dist;
      r_halted      <= w_halted;
      r_fault       <= w_fault;
    end
  end

endmodule

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: directed + randomized checks of fetch_ctl against a PC-level reference model.
module tb_fetch_ctl;

  localparam int unsigned MEM_TIMEOUT = 15;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] pc_i;
  logic [7:0] mem_addr_o;
  logic       mem_req_o;
  logic       mem_ack_i;
  logic [7:0] mem_data_i;
  logic       flag_z_i;
  logic [7:0] instr_o;
  logic       instr_valid_o;
  logic       exec_done_i;
  logic       pc_adv_o;
  logic       jump_up_o;
  logic       jump_down_o;
  logic [3:0] jump_dist_o;
  logic       halted_o;
  logic       fault_o;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  fetch_ctl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .mem_addr_o(mem_addr_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .flag_z_i(flag_z_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .exec_done_i(exec_done_i), .pc_adv_o(pc_adv_o), .jump_up_o(jump_up_o),
    .jump_down_o(jump_down_o), .jump_dist_o(jump_dist_o), .halted_o(halted_o),
    .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: where the PC must land after this opcode, given Z.
  function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [7:0] opc,
                                               input logic z);
    int p;
    int d;
    p = int'(pc);
    d = int'(opc[3:0]);
    case (opc[7:4])
      4'hC:    p = p + d;
      4'hD:    p = p - d;
      4'hE:    p = z ? p + d : p + 1;
      4'hF:    p = z ? p - d : p + 1;
      default: p = p + 1;
    endcase
    return 8'(p & 255);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_adv"},   32'(pc_adv_o), 32'd0);
    chk({tag, "_req"},   32'(mem_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr"}, 32'(instr_o), 32'd0);
    chk({tag, "_jump"},  32'({jump_up_o, jump_down_o, jump_dist_o}), 32'd0);
    chk({tag, "_hf"},    32'({halted_o, fault_o}), 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    chk_idle_outputs("reset");
    #2;
    rst_i = 1'b0;
    tick();
    chk("post_reset_req", 32'(mem_req_o), 32'd1);
  endtask

  // One full instruction: optional ack wait, ack, decode, (exec), advance.
  task automatic run_instr(input logic [7:0] opc, input logic z, input int ack_dly,
                           input int exec_dly);
    logic [7:0] exp_pc;
    logic [7:0] obs_pc;
    exp_pc = model_next_pc(pc_i, opc, z);
    for (int i = 0; i < ack_dly; i++) begin
      chk("req_wait", 32'(mem_req_o), 32'd1);
      exec_done_i = 1'($urandom);
      flag_z_i    = 1'($urandom);
      tick();
    end
    chk("addr", 32'(mem_addr_o), 32'(pc_i));
    chk("req", 32'(mem_req_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_data_i  = opc;
    flag_z_i    = ~z;
    exec_done_i = 1'b0;
    tick();
    mem_ack_i   = 1'b0;
    mem_data_i  = 8'($urandom);
    flag_z_i    = z;
    exec_done_i = 1'($urandom);
    chk("req_drop", 32'(mem_req_o), 32'd0);
    chk("decode_adv", 32'(pc_adv_o), 32'd0);
    tick();
    flag_z_i    = 1'($urandom);
    exec_done_i = 1'b0;
    if (opc == 8'h00) begin
      chk("halt_flag", 32'(halted_o), 32'd1);
      chk("halt_req", 32'(mem_req_o), 32'd0);
      chk("halt_adv", 32'(pc_adv_o), 32'd0);
    end else begin
      if (opc[7:6] != 2'b11) begin
        for (int k = 1; k <= exec_dly; k++) begin
          chk("exec_valid", 32'(instr_valid_o), 32'd1);
          chk("exec_instr", 32'(instr_o), 32'(opc));
          chk("exec_adv", 32'(pc_adv_o), 32'd0);
          if (k == exec_dly) exec_done_i = 1'b1;
          tick();
        end
        exec_done_i = 1'b0;
        chk("exec_valid_drop", 32'(instr_valid_o), 32'd0);
      end
      chk("adv", 32'(pc_adv_o), 32'd1);
      chk("adv_excl", 32'(jump_up_o & jump_down_o), 32'd0);
      if (jump_up_o)        obs_pc = pc_i + 8'(jump_dist_o);
      else if (jump_down_o) obs_pc = pc_i - 8'(jump_dist_o);
      else                  obs_pc = pc_i + 8'd1;
      chk("next_pc", 32'(obs_pc), 32'(exp_pc));
      pc_i = exp_pc;
      tick();
      chk("after_adv", 32'({pc_adv_o, jump_up_o, jump_down_o, jump_dist_o}), 32'd0);
      chk("refetch_req", 32'(mem_req_o), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] opc;
    rst_i       = 1'b1;
    pc_i        = 8'd10;
    mem_ack_i   = 1'b0;
    mem_data_i  = 8'h00;
    flag_z_i    = 1'b0;
    exec_done_i = 1'b0;
    #2;
    chk_idle_outputs("init_reset");
    #10;
    rst_i = 1'b0;
    tick();
    chk("first_req", 32'(mem_req_o), 32'd1);

    // Unconditional up, conditional down untaken/taken, execute path.
    run_instr(8'hC5, 1'b0, 0, 1);
    chk("pc_after_c5", 32'(pc_i), 32'd15);
    run_instr(8'hF3, 1'b0, 0, 1);
    run_instr(8'hF3, 1'b1, 1, 1);
    chk("pc_after_f3", 32'(pc_i), 32'd13);
    run_instr(8'h42, 1'b0, 0, 4);
    run_instr(8'hE0, 1'b1, 2, 1);
    run_instr(8'hD0, 1'b0, 0, 1);
    run_instr(8'hD9, 1'b1, 0, 1);

    // Reset in the middle of EXEC: immediate clear, clean refetch, no strobe.
    mem_ack_i  = 1'b1;
    mem_data_i = 8'h37;
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(instr_valid_o), 32'd1);
    #3;
    rst_i = 1'b1;
    #1;
    chk_idle_outputs("mid_exec_rst");
    #1;
    rst_i = 1'b0;
    tick();
    chk("rst_refetch_req", 32'(mem_req_o), 32'd1);
    chk("rst_refetch_adv", 32'(pc_adv_o), 32'd0);
    run_instr(8'h37, 1'b0, 0, 2);

    // Memory timeout.
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      chk("to_req", 32'(mem_req_o), 32'd1);
      chk("to_fault_early", 32'(fault_o), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("fault_flag", 32'(fault_o), 32'd1);
      chk("fault_req", 32'(mem_req_o), 32'd0);
      chk("fault_adv", 32'(pc_adv_o), 32'd0);
      mem_ack_i   = 1'($urandom);
      exec_done_i = 1'($urandom);
      tick();
    end
    mem_ack_i   = 1'b0;
    exec_done_i = 1'b0;
    do_reset();

    // HALT is terminal.
    run_instr(8'h00, 1'b0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("halt_hold", 32'({halted_o, mem_req_o, pc_adv_o, instr_valid_o}), 32'h8);
      mem_ack_i   = 1'($urandom);
      exec_done_i = 1'($urandom);
      tick();
    end
    mem_ack_i   = 1'b0;
    exec_done_i = 1'b0;
    do_reset();

    // Randomized instruction stream; half the opcodes forced into the branch group.
    for (int n = 0; n < 150; n++) begin
      opc = 8'($urandom);
      if (n[0]) opc[7:6] = 2'b11;
      if (opc == 8'h00) opc = 8'h01;
      run_instr(opc, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(4, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
